// File: rtl/tdm_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tdm_frame_scheduler
// Purpose  : Frame scheduler between two I2S sample sources and a TDM
//            transmitter. Buffers one sample per channel behind a
//            valid/ready handshake and emits a frame strobe carrying both
//            samples once every G_FRAME_MCLKS master clocks. Handles start-up
//            priming, underrun substitution and a clean stop on disable.
// Build    : TDM_SCHED_HOLD_LAST_EN
//              defined   - an underrun slot repeats its previous strobe value
//              undefined - an underrun slot is muted (zero)
// Ports    : in_mclk             sole clock, rising edge
//            in_rst_n            synchronous active-low reset
//            in_enable           run request
//            in_sample_n         channel-n sample         (n = 1, 2)
//            in_valid_n          channel-n sample valid
//            out_ready_n         channel-n buffer can accept
//            out_frame_n         slot-n data to transmitter
//            out_frame_strobe    one-cycle frame load pulse
//            out_underrun        one-cycle pulse, frame used substitute data
//            out_underrun_count  saturating underrun-frame count
//            out_running         high while in RUN
// Revision : 1.0 - initial release
// ============================================================================
module tdm_frame_scheduler #(
  parameter int G_BITS        = 16,
  parameter int G_FRAME_MCLKS = 64
) (
  input  logic              in_mclk,
  input  logic              in_rst_n,
  input  logic              in_enable,
  input  logic [G_BITS-1:0] in_sample_1,
  input  logic              in_valid_1,
  output logic              out_ready_1,
  input  logic [G_BITS-1:0] in_sample_2,
  input  logic              in_valid_2,
  output logic              out_ready_2,
  output logic [G_BITS-1:0] out_frame_1,
  output logic [G_BITS-1:0] out_frame_2,
  output logic              out_frame_strobe,
  output logic              out_underrun,
  output logic [7:0]        out_underrun_count,
  output logic              out_running
);

  localparam int                 c_CNT_W     = $clog2(G_FRAME_MCLKS);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(G_FRAME_MCLKS - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
  localparam logic [7:0]         c_COUNT_MAX = 8'hFF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t              r_state;
  logic [c_CNT_W-1:0]  r_cnt;

  // per-channel single-entry buffers
  logic                r_full_1;
  logic                r_full_2;
  logic [G_BITS-1:0]   r_buf_1;
  logic [G_BITS-1:0]   r_buf_2;

  // registered outputs
  logic                r_ready_1;
  logic                r_ready_2;
  logic [G_BITS-1:0]   r_frame_1;
  logic [G_BITS-1:0]   r_frame_2;
  logic                r_strobe;
  logic                r_underrun;
  logic [7:0]          r_ucount;
  logic                r_running;

  logic                w_xfer_1;
  logic                w_xfer_2;
  logic                w_tick;
  logic                w_short;
  logic [G_BITS-1:0]   w_sub_1;
  logic [G_BITS-1:0]   w_sub_2;

  // ready is registered, so a transfer is decided purely by flop state
  assign w_xfer_1 = in_valid_1 & r_ready_1;
  assign w_xfer_2 = in_valid_2 & r_ready_2;

  // frame tick: first cycle of every frame period while running
  assign w_tick  = (r_state == S_RUN) && (r_cnt == '0);
  assign w_short = !(r_full_1 && r_full_2);

  // substitute data for a slot whose buffer is empty at the tick
`ifdef TDM_SCHED_HOLD_LAST_EN
  assign w_sub_1 = r_frame_1;
  assign w_sub_2 = r_frame_2;
`else
  assign w_sub_1 = '0;
  assign w_sub_2 = '0;
`endif

  always_ff @(posedge in_mclk) begin
    if (!in_rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_full_1   <= 1'b0;
      r_full_2   <= 1'b0;
      r_buf_1    <= '0;
      r_buf_2    <= '0;
      r_ready_1  <= 1'b0;
      r_ready_2  <= 1'b0;
      r_frame_1  <= '0;
      r_frame_2  <= '0;
      r_strobe   <= 1'b0;
      r_underrun <= 1'b0;
      r_ucount   <= '0;
      r_running  <= 1'b0;
    end else begin
      // pulses default low; only the frame tick raises them
      r_strobe   <= 1'b0;
      r_underrun <= 1'b0;

      // sample capture is harmless whenever a handshake completes; the
      // full flags below decide whether the data is actually kept
      if (w_xfer_1) r_buf_1 <= in_sample_1;
      if (w_xfer_2) r_buf_2 <= in_sample_2;

      case (r_state)
        S_IDLE: begin
          r_full_1  <= 1'b0;
          r_full_2  <= 1'b0;
          r_cnt     <= '0;
          r_running <= 1'b0;
          if (in_enable) begin
            r_state   <= S_PRIME;
            r_ready_1 <= 1'b1;
            r_ready_2 <= 1'b1;
          end else begin
            r_ready_1 <= 1'b0;
            r_ready_2 <= 1'b0;
          end
        end

        S_PRIME: begin
          if (!in_enable) begin
            // abandon priming and flush anything collected so far
            r_state   <= S_IDLE;
            r_full_1  <= 1'b0;
            r_full_2  <= 1'b0;
            r_ready_1 <= 1'b0;
            r_ready_2 <= 1'b0;
          end else if (r_full_1 && r_full_2) begin
            // both buffers primed: the first RUN cycle is a frame tick
            r_state   <= S_RUN;
            r_cnt     <= '0;
            r_running <= 1'b1;
            r_ready_1 <= 1'b0;
            r_ready_2 <= 1'b0;
          end else begin
            r_full_1  <= r_full_1 | w_xfer_1;
            r_full_2  <= r_full_2 | w_xfer_2;
            r_ready_1 <= !(r_full_1 | w_xfer_1);
            r_ready_2 <= !(r_full_2 | w_xfer_2);
          end
        end

        S_RUN: begin
          if (w_tick) begin
            if (in_enable) begin
              r_frame_1  <= r_full_1 ? r_buf_1 : w_sub_1;
              r_frame_2  <= r_full_2 ? r_buf_2 : w_sub_2;
              r_strobe   <= 1'b1;
              r_underrun <= w_short;
              if (w_short && (r_ucount != c_COUNT_MAX)) begin
                r_ucount <= r_ucount + 8'd1;
              end
              // buffers are consumed; a sample accepted on this very cycle
              // (only possible into an empty buffer) is kept for next frame
              r_full_1  <= w_xfer_1;
              r_full_2  <= w_xfer_2;
              r_ready_1 <= !w_xfer_1;
              r_ready_2 <= !w_xfer_2;
              r_cnt     <= c_CNT_ONE;
            end else begin
              // disable takes effect on a frame boundary: no strobe, stop
              r_state   <= S_IDLE;
              r_running <= 1'b0;
              r_full_1  <= 1'b0;
              r_full_2  <= 1'b0;
              r_ready_1 <= 1'b0;
              r_ready_2 <= 1'b0;
              r_cnt     <= '0;
            end
          end else begin
            r_full_1  <= r_full_1 | w_xfer_1;
            r_full_2  <= r_full_2 | w_xfer_2;
            r_ready_1 <= !(r_full_1 | w_xfer_1);
            r_ready_2 <= !(r_full_2 | w_xfer_2);
            r_cnt     <= (r_cnt == c_CNT_LAST) ? '0 : (r_cnt + c_CNT_ONE);
          end
        end

        default: begin
          r_state   <= S_IDLE;
          r_full_1  <= 1'b0;
          r_full_2  <= 1'b0;
          r_ready_1 <= 1'b0;
          r_ready_2 <= 1'b0;
          r_running <= 1'b0;
          r_cnt     <= '0;
        end
      endcase
    end
  end

  assign out_ready_1        = r_ready_1;
  assign out_ready_2        = r_ready_2;
  assign out_frame_1        = r_frame_1;
  assign out_frame_2        = r_frame_2;
  assign out_frame_strobe   = r_strobe;
  assign out_underrun       = r_underrun;
  assign out_underrun_count = r_ucount;
  assign out_running        = r_running;

endmodule
`default_nettype wire

// File: tb/tb_tdm_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_tdm_frame_scheduler
// Purpose  : Self-checking bench for tdm_frame_scheduler. A frame-level
//            model (sample queues, run start time, frame arithmetic) predicts
//            every output each cycle; directed steps add literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tdm_frame_scheduler;

  localparam int BITS = 16;
  localparam int F    = 64;

`ifdef TDM_SCHED_HOLD_LAST_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  localparam int M_IDLE  = 0;
  localparam int M_PRIME = 1;
  localparam int M_RUN   = 2;

  logic            in_mclk = 1'b0;
  logic            in_rst_n;
  logic            in_enable;
  logic [BITS-1:0] in_sample_1;
  logic            in_valid_1;
  logic            out_ready_1;
  logic [BITS-1:0] in_sample_2;
  logic            in_valid_2;
  logic            out_ready_2;
  logic [BITS-1:0] out_frame_1;
  logic [BITS-1:0] out_frame_2;
  logic            out_frame_strobe;
  logic            out_underrun;
  logic [7:0]      out_underrun_count;
  logic            out_running;

  always #5 in_mclk = ~in_mclk;

  tdm_frame_scheduler #(
    .G_BITS        (BITS),
    .G_FRAME_MCLKS (F)
  ) dut (
    .in_mclk            (in_mclk),
    .in_rst_n           (in_rst_n),
    .in_enable          (in_enable),
    .in_sample_1        (in_sample_1),
    .in_valid_1         (in_valid_1),
    .out_ready_1        (out_ready_1),
    .in_sample_2        (in_sample_2),
    .in_valid_2         (in_valid_2),
    .out_ready_2        (out_ready_2),
    .out_frame_1        (out_frame_1),
    .out_frame_2        (out_frame_2),
    .out_frame_strobe   (out_frame_strobe),
    .out_underrun       (out_underrun),
    .out_underrun_count (out_underrun_count),
    .out_running        (out_running)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  int              m_mode = M_IDLE;
  logic [BITS-1:0] q1[$];
  logic [BITS-1:0] q2[$];
  logic [BITS-1:0] m_frame_1  = '0;
  logic [BITS-1:0] m_frame_2  = '0;
  bit              m_strobe   = 1'b0;
  bit              m_underrun = 1'b0;
  int              m_count    = 0;
  bit              m_running  = 1'b0;
  bit              m_ready_1  = 1'b0;
  bit              m_ready_2  = 1'b0;

  initial begin : model
    int              cyc;
    int              run_t0;
    bit              a1, a2, miss;
    logic [BITS-1:0] s1, s2;
    cyc    = 0;
    run_t0 = 0;
    forever begin
      @(posedge in_mclk);
      // cycle 'cyc' just ended; decide what the next cycle shows
      a1 = in_valid_1 && m_ready_1;
      a2 = in_valid_2 && m_ready_2;
      s1 = in_sample_1;
      s2 = in_sample_2;
      m_strobe   = 1'b0;
      m_underrun = 1'b0;
      if (!in_rst_n) begin
        m_mode = M_IDLE;
        q1.delete();
        q2.delete();
        m_frame_1 = '0;
        m_frame_2 = '0;
        m_count   = 0;
      end else if (m_mode == M_IDLE) begin
        if (in_enable) m_mode = M_PRIME;
      end else if (m_mode == M_PRIME) begin
        if (!in_enable) begin
          m_mode = M_IDLE;
          q1.delete();
          q2.delete();
        end else if (q1.size() > 0 && q2.size() > 0) begin
          m_mode = M_RUN;
          run_t0 = cyc + 1;
        end else begin
          if (a1) q1.push_back(s1);
          if (a2) q2.push_back(s2);
        end
      end else begin
        if (((cyc - run_t0) % F) == 0) begin
          if (in_enable) begin
            miss     = 1'b0;
            m_strobe = 1'b1;
            if (q1.size() > 0) m_frame_1 = q1.pop_front();
            else begin miss = 1'b1; m_frame_1 = HOLD ? m_frame_1 : '0; end
            if (q2.size() > 0) m_frame_2 = q2.pop_front();
            else begin miss = 1'b1; m_frame_2 = HOLD ? m_frame_2 : '0; end
            if (miss) begin
              m_underrun = 1'b1;
              if (m_count < 255) m_count++;
            end
            if (a1) q1.push_back(s1);
            if (a2) q2.push_back(s2);
          end else begin
            m_mode = M_IDLE;
            q1.delete();
            q2.delete();
          end
        end else begin
          if (a1) q1.push_back(s1);
          if (a2) q2.push_back(s2);
        end
      end
      m_ready_1 = (m_mode != M_IDLE) && (q1.size() == 0);
      m_ready_2 = (m_mode != M_IDLE) && (q2.size() == 0);
      m_running = (m_mode == M_RUN);
      cyc++;
    end
  end

  // ------------------------------------------------------ per-cycle compare
  initial begin : compare
    forever begin
      @(negedge in_mclk);
      if (chk_on) begin
        chk("strobe",    {31'd0, out_frame_strobe}, {31'd0, m_strobe});
        chk("underrun",  {31'd0, out_underrun},     {31'd0, m_underrun});
        chk("count",     {24'd0, out_underrun_count}, m_count);
        chk("running",   {31'd0, out_running},      {31'd0, m_running});
        chk("ready_1",   {31'd0, out_ready_1},      {31'd0, m_ready_1});
        chk("ready_2",   {31'd0, out_ready_2},      {31'd0, m_ready_2});
        chk("frame_1",   {16'd0, out_frame_1},      {16'd0, m_frame_1});
        chk("frame_2",   {16'd0, out_frame_2},      {16'd0, m_frame_2});
      end
    end
  end

  // ------------------------------------------------------------- stimulus
  task automatic step(input int n);
    repeat (n) begin
      @(posedge in_mclk);
      #1;
    end
  endtask

  // Entered on a strobe cycle; offers one sample per channel at the given
  // offsets (0 = withhold) and returns on the next expected strobe cycle.
  task automatic period(input int o1, input logic [BITS-1:0] v1,
                        input int o2, input logic [BITS-1:0] v2);
    for (int j = 1; j <= F; j++) begin
      step(1);
      in_sample_1 = v1;
      in_sample_2 = v2;
      in_valid_1  = (j == o1);
      in_valid_2  = (j == o2);
    end
    in_valid_1 = 1'b0;
    in_valid_2 = 1'b0;
    chk("period_strobe", {31'd0, out_frame_strobe}, 32'd1);
  endtask

  logic [BITS-1:0] tab_1 [6] = '{16'h1001, 16'h1002, 16'h1003, 16'h1004, 16'h1005, 16'h1006};
  logic [BITS-1:0] tab_2 [6] = '{16'h2001, 16'h2002, 16'h2003, 16'h2004, 16'h2005, 16'h2006};

  initial begin : driver
    in_rst_n    = 1'b0;
    in_enable   = 1'b0;
    in_sample_1 = '0;
    in_sample_2 = '0;
    in_valid_1  = 1'b0;
    in_valid_2  = 1'b0;

    // reset state
    step(3);
    chk_on = 1'b1;
    chk("rst_strobe",  {31'd0, out_frame_strobe}, 32'd0);
    chk("rst_count",   {24'd0, out_underrun_count}, 32'd0);
    chk("rst_ready_1", {31'd0, out_ready_1}, 32'd0);
    chk("rst_running", {31'd0, out_running}, 32'd0);
    in_rst_n = 1'b1;
    step(2);

    // start-up: enable, then both samples offered on the same cycle T
    in_enable = 1'b1;
    step(1);
    chk("prime_ready_1", {31'd0, out_ready_1}, 32'd1);
    chk("prime_ready_2", {31'd0, out_ready_2}, 32'd1);
    in_sample_1 = 16'h1234;
    in_sample_2 = 16'hABCD;
    in_valid_1  = 1'b1;
    in_valid_2  = 1'b1;
    step(1);                                   // T+1: buffers full
    in_valid_1 = 1'b0;
    in_valid_2 = 1'b0;
    chk("full_ready_1", {31'd0, out_ready_1}, 32'd0);
    step(1);                                   // T+2: RUN, tick cycle
    chk("t2_running", {31'd0, out_running}, 32'd1);
    chk("t2_strobe",  {31'd0, out_frame_strobe}, 32'd0);
    step(1);                                   // T+3: first strobe
    chk("first_strobe",  {31'd0, out_frame_strobe}, 32'd1);
    chk("first_frame_1", {16'd0, out_frame_1}, 32'h1234);
    chk("first_frame_2", {16'd0, out_frame_2}, 32'hABCD);
    chk("first_underrun", {31'd0, out_underrun}, 32'd0);

    // steady state: one sample pair per frame at random phase
    for (int k = 0; k < 6; k++) begin
      period($urandom_range(1, 50), tab_1[k], $urandom_range(1, 50), tab_2[k]);
      chk("steady_frame_1", {16'd0, out_frame_1}, {16'd0, tab_1[k]});
      chk("steady_frame_2", {16'd0, out_frame_2}, {16'd0, tab_2[k]});
      chk("steady_underrun", {31'd0, out_underrun}, 32'd0);
    end

    // underrun on channel 2 only
    period(5, 16'hAAAA, 9, 16'h5555);
    chk("pre_ur_frame_2", {16'd0, out_frame_2}, 32'h5555);
    period(7, 16'h0001, 0, 16'h0000);
    chk("ur_frame_1",  {16'd0, out_frame_1}, 32'h0001);
    chk("ur_frame_2",  {16'd0, out_frame_2}, HOLD ? 32'h5555 : 32'h0000);
    chk("ur_pulse",    {31'd0, out_underrun}, 32'd1);
    chk("ur_count",    {24'd0, out_underrun_count}, 32'd1);

    // saturation: 300 empty frames, strobe every frame
    for (int k = 0; k < 300; k++) period(0, 16'h0000, 0, 16'h0000);
    chk("sat_count", {24'd0, out_underrun_count}, 32'd255);
    step(1);
    chk("sat_pulse_clear", {31'd0, out_underrun}, 32'd0);

    // disable 10 cycles after a strobe
    step(9);
    in_enable = 1'b0;
    step(53);                                  // S+63: last RUN cycle
    chk("dis_running_hold", {31'd0, out_running}, 32'd1);
    step(1);                                   // S+64: IDLE, no strobe
    chk("dis_strobe",  {31'd0, out_frame_strobe}, 32'd0);
    chk("dis_running", {31'd0, out_running}, 32'd0);
    chk("dis_ready_1", {31'd0, out_ready_1}, 32'd0);
    chk("dis_ready_2", {31'd0, out_ready_2}, 32'd0);
    step(20);

    // re-enable and prime again
    in_enable = 1'b1;
    step(1);
    in_sample_1 = 16'hC0DE;
    in_sample_2 = 16'hBEEF;
    in_valid_1  = 1'b1;
    in_valid_2  = 1'b1;
    step(1);
    in_valid_1 = 1'b0;
    in_valid_2 = 1'b0;
    step(2);
    chk("re_strobe",  {31'd0, out_frame_strobe}, 32'd1);
    chk("re_frame_1", {16'd0, out_frame_1}, 32'hC0DE);
    chk("re_frame_2", {16'd0, out_frame_2}, 32'hBEEF);

    // fill both buffers, then reset mid-frame
    step(1);
    in_sample_1 = 16'h1111;
    in_sample_2 = 16'h2222;
    in_valid_1  = 1'b1;
    in_valid_2  = 1'b1;
    step(1);
    in_valid_1 = 1'b0;
    in_valid_2 = 1'b0;
    step(10);
    in_rst_n = 1'b0;
    step(1);
    chk("mrst_frame_1", {16'd0, out_frame_1}, 32'd0);
    chk("mrst_frame_2", {16'd0, out_frame_2}, 32'd0);
    chk("mrst_count",   {24'd0, out_underrun_count}, 32'd0);
    chk("mrst_running", {31'd0, out_running}, 32'd0);
    chk("mrst_ready_1", {31'd0, out_ready_1}, 32'd0);
    in_rst_n = 1'b1;
    step(150);                                 // enabled but unprimed
    chk("unprimed_strobe",  {31'd0, out_frame_strobe}, 32'd0);
    chk("unprimed_running", {31'd0, out_running}, 32'd0);
    in_sample_1 = 16'h3333;
    in_sample_2 = 16'h4444;
    in_valid_1  = 1'b1;
    in_valid_2  = 1'b1;
    step(1);
    in_valid_1 = 1'b0;
    in_valid_2 = 1'b0;
    step(2);
    chk("post_rst_strobe",  {31'd0, out_frame_strobe}, 32'd1);
    chk("post_rst_frame_1", {16'd0, out_frame_1}, 32'h3333);
    chk("post_rst_frame_2", {16'd0, out_frame_2}, 32'h4444);
    step(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/tdm_frame_scheduler.md
# tdm_frame_scheduler

Frame scheduler that sits between the two I2S sample sources and the TDM transmitter. It buffers one sample per channel with a valid/ready handshake and issues a frame strobe with both samples at a fixed rate of one frame per `G_FRAME_MCLKS` master clocks. It handles start-up priming, underrun substitution and clean stop on disable. Its outputs drive the transmitter's `frame_1`/`frame_2`/`frame_strobe` inputs directly.

## Interface

Parameters:

- `G_BITS`, 16, sample width per channel.
- `G_FRAME_MCLKS`, 64, `in_mclk` cycles per TDM frame. Legal range is ≥ 2; default = 4·`G_BITS` (two slots, sclk = mclk/2).

Ports:

- `in_mclk`  in  1  sole clock; all logic on its rising edge.
- `in_rst_n`  in  1  reset; synchronous, active-low.
- `in_enable`  in  1  run request.
- `in_sample_1`  in  `G_BITS`  channel-1 sample.
- `in_valid_1`  in  1  channel-1 sample valid.
- `out_ready_1`  out  1  channel-1 buffer can accept.
- `in_sample_2`  in  `G_BITS`  channel-2 sample.
- `in_valid_2`  in  1  channel-2 sample valid.
- `out_ready_2`  out  1  channel-2 buffer can accept.
- `out_frame_1`  out  `G_BITS`  slot-1 data to transmitter.
- `out_frame_2`  out  `G_BITS`  slot-2 data to transmitter.
- `out_frame_strobe`  out  1  one-cycle load pulse.
- `out_underrun`  out  1  one-cycle pulse, frame used substitute data.
- `out_underrun_count`  out  8  saturating underrun-frame count.
- `out_running`  out  1  high in RUN.

## Operation

- **Per-channel buffer:** one sample register plus `full` flag.
  - `out_ready_n` = `!full_n` while state ≠ IDLE; 0 in IDLE.
  - A transfer happens when valid && ready. It sets `full` and captures the sample.
- **States:**
  - IDLE: both buffers flushed (`full` = 0), counter = 0. `in_enable` = 1 → PRIME.
  - PRIME: buffers accept samples; no strobes.
    - `in_enable` = 0 → IDLE.
    - `full_1` && `full_2` → RUN, period counter := 0.
  - RUN: period counter counts 0..`G_FRAME_MCLKS`-1 and wraps. At counter == 0 the **frame tick** occurs:
    - If `in_enable` = 1: register `out_frame_1`/`out_frame_2`, pulse `out_frame_strobe`, clear both `full` flags.
    - If `in_enable` = 0: no strobe, → IDLE.
- **Underrun:** at a tick with `full_n` = 0, slot n takes substitute data (see Configuration).
  - The strobe is still issued.
  - `out_underrun` pulses once per frame, even if both slots underrun.
  - `out_underrun_count` increments by 1 and saturates at 255. It is cleared only by reset.
- **Simultaneous valid and tick:** a full buffer has ready = 0, so there is no accept on the consume cycle. Ready returns the following cycle.
- `out_running` = (state == RUN).

## Timing

- **Reset:** state IDLE, buffers empty, counter 0. All outputs are 0: frames, strobe, underrun pulse, count, running, readys.
- All outputs are registered.
- `in_enable` sampled 1 in IDLE at cycle T → PRIME at T+1 → `out_ready_n` = 1 at T+1.
- Both `full` flags set at cycle T → RUN at T+1 (counter 0) → `out_frame_strobe` = 1 at T+2, with data valid in the same cycle.
- Subsequent strobes occur exactly every `G_FRAME_MCLKS` cycles.
- `out_frame_1`/`out_frame_2` hold their values between strobes.
- **Enable deasserted mid-RUN:** the current frame period completes. At the next tick there is no strobe and the block enters IDLE. The last strobe's data is never truncated.
- **Reset asserted mid-frame:** reset wins on that edge; all state is as at reset.

## Configuration

- Macro `TDM_SCHED_HOLD_LAST_EN`.
  - **Defined:** an underrun slot repeats the value it carried in the previous strobe (0 if none since reset).
  - **Undefined:** an underrun slot outputs 0 (mute).
- The counter, pulse and timing are identical in both builds.

## Test plan

- **Start-up:** reset, `enable` = 1, deliver `0x1234` on ch1 and `0xABCD` on ch2 at the same cycle T.
  - → strobe at T+3 (accept at T, full at T+1) with `frame_1` = `0x1234`, `frame_2` = `0xABCD`.
  - → next strobe exactly 64 cycles later.
- **Steady state:** new samples arrive every 64 cycles with a random phase offset.
  - → no underrun; each sample appears in exactly one strobe, in order.
  - → ready is low from accept until consume.
- **Underrun:** withhold ch2 for one frame after `0x5555`; ch1 sends `0x0001`.
  - → strobe carries `frame_1` = `0x0001`.
  - → `frame_2` = `0x5555` (macro defined) or `0x0000` (undefined).
  - → `out_underrun` pulses once; count = 1.
- **Count saturation:** leave both channels empty for 300 frames in RUN.
  - → count stops at 255; a strobe still occurs every frame.
- **Disable:** drop `enable` 10 cycles after a strobe.
  - → no further strobe; IDLE at the next tick (54 cycles later); readys go 0; `running` goes 0.
- **Reset mid-frame:** assert `in_rst_n` = 0 for 1 cycle in RUN with both buffers full.
  - → all outputs 0 on the next cycle.
  - → a re-enable requires fresh priming before the first strobe.
